l5_fc_argmax: RTL and testbench

Final classifier stage, directly downstream of layer 4. It captures the 64 ReLU'd layer-4 activations, delivered as four groups of 16 parallel 18-bit words. It computes 10 class scores as a 64×10 fully-connected layer with signed 9-bit weights and 9-bit biases, then runs a sequential argmax. The result is a 4-bit digit plus a level `vld`, held until `tx_done` clears the frame.

---
 rtl/l5_fc_argmax.sv | 180 ++++++++++++++++++
 tb/tb_l5_fc_argmax.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l5_fc_argmax.sv
// l5_fc_argmax: final classifier stage. Captures 64 layer-4 activations
// (4 groups x 16 lanes), runs a 64x10 fully-connected layer against a
// registered weight ROM, adds biases and picks the highest class score.
//
// Handshake: strt is a level request; the frame starts on the first cycle
// strt is sampled high in IDLE. vld is a level that holds the result until
// tx_done is sampled. tx_done clears the frame from any state and
// overrides a simultaneous strt.
//
// The weight ROM (l5_rom) and the bias ROM (l5_rom_b) are constants
// supplied at instantiation through WGT and BIAS:
//   weight of input i, class c : WGT [90*i + 9*c +: 9]  (signed)
//   bias of class c            : BIAS[9*c +: 9]         (signed)
// The RD_LAT lower bound is 1: group 0 cannot arrive in the start cycle.
module l5_fc_argmax #(
    parameter int RD_LAT = 1,
    parameter int N_IN   = 64,
    parameter int N_CLS  = 10,
    parameter logic [N_IN*N_CLS*9-1:0] WGT  = '0,
    parameter logic [N_CLS*9-1:0]      BIAS = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                strt,
    input  logic                tx_done,
    input  logic [15:0][17:0]   din,
    output logic [3:0]          digit,
    output logic signed [35:0]  score,
    output logic                vld,
    output logic                busy
);

    localparam int         WW       = N_CLS * 9;
    localparam logic [7:0] CC_FIRST = 8'(RD_LAT);
    localparam logic [7:0] CC_LAST  = 8'(RD_LAT + 3);
    localparam logic [6:0] MAC_LAST = 7'(N_IN);
    localparam logic [3:0] ARG_LAST = 4'(N_CLS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CAPT, S_MAC, S_BIAS, S_ARG, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    cc;                // capture counter, cycles since start
    logic [6:0]    mc;                // MAC cycle 0..64
    logic [3:0]    ak;                // argmax class index 0..9
    logic [17:0]   dbuf [N_IN];
    logic [WW-1:0] l5_rom_q;
    logic [WW-1:0] l5_rom_b;
    logic [35:0]   acc    [N_CLS];
    logic [26:0]   op_a;
    logic [26:0]   op_b   [N_CLS];
    logic [26:0]   prod   [N_CLS];
    logic [35:0]   prod_x [N_CLS];
    logic [35:0]   best_s, nb_s, acc_sel;
    logic [3:0]    best_i, nb_i;
    logic [5:0]    bidx;
    logic [1:0]    grp;

    assign l5_rom_b = BIAS;
    // The ROM word used in MAC cycle i was addressed in cycle i-1.
    assign bidx = 6'(mc - 7'd1);
    assign grp  = 2'(cc - CC_FIRST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode and status outputs; tx_done dominates everything.
    always_comb begin
        state_d = state_q;
        vld     = 1'b0;
        busy    = 1'b0;
        if (tx_done) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (strt) state_d = S_CAPT;
                S_CAPT: if (cc == CC_LAST) state_d = S_MAC;
                S_MAC:  if (mc == MAC_LAST) state_d = S_BIAS;
                S_BIAS: state_d = S_ARG;
                S_ARG:  if (ak == ARG_LAST) state_d = S_DONE;
                default: state_d = state_q;
            endcase
        end
        vld  = (state_q == S_DONE);
        busy = (state_q != S_IDLE) && (state_q != S_DONE);
    end

    // Weight ROM: registered read, address is the MAC cycle number.
    always_ff @(posedge clk) begin
        l5_rom_q <= WGT[int'(mc[5:0])*WW +: WW];
    end

    // Activation buffer: group g lands when cc = RD_LAT + g.
    always_ff @(posedge clk) begin
        if (state_q == S_CAPT && !tx_done && cc >= CC_FIRST && cc <= CC_LAST) begin
            for (int n = 0; n < 16; n++) dbuf[{grp, 4'(n)}] <= din[n];
        end
    end

    // 18x9 signed products, done at 27 bits then sign-extended to 36.
    always_comb begin
        op_a = {{9{dbuf[bidx][17]}}, dbuf[bidx]};
        for (int c = 0; c < N_CLS; c++) begin
            op_b[c]   = {{18{l5_rom_q[9*c+8]}}, l5_rom_q[9*c +: 9]};
            prod[c]   = op_a * op_b[c];
            prod_x[c] = {{9{prod[c][26]}}, prod[c]};
        end
    end

    // Running-best candidate: first class loads, later ones need strictly greater.
    always_comb begin
        acc_sel = '0;
        if (ak < 4'(N_CLS)) acc_sel = acc[ak];
        nb_s = best_s;
        nb_i = best_i;
        if (ak == 4'd0 || $signed(acc_sel) > $signed(best_s)) begin
            nb_s = acc_sel;
            nb_i = ak;
        end
    end

    // Counters, accumulators, argmax and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc     <= '0;
            mc     <= '0;
            ak     <= '0;
            best_s <= '0;
            best_i <= '0;
            digit  <= '0;
            score  <= '0;
            for (int c = 0; c < N_CLS; c++) acc[c] <= '0;
        end else if (tx_done) begin
            cc     <= '0;
            mc     <= '0;
            ak     <= '0;
            best_s <= '0;
            best_i <= '0;
            digit  <= '0;
            score  <= '0;
        end else begin
            case (state_q)
                S_IDLE: cc <= strt ? 8'd1 : 8'd0;
                S_CAPT: begin
                    cc <= cc + 8'd1;
                    if (cc == CC_LAST) begin
                        mc <= '0;
                        for (int c = 0; c < N_CLS; c++) acc[c] <= '0;
                    end
                end
                S_MAC: begin
                    mc <= mc + 7'd1;
                    if (mc != 7'd0) begin
                        for (int c = 0; c < N_CLS; c++) acc[c] <= acc[c] + prod_x[c];
                    end
                end
                S_BIAS: begin
                    ak <= '0;
                    for (int c = 0; c < N_CLS; c++)
                        acc[c] <= acc[c] + {{27{l5_rom_b[9*c+8]}}, l5_rom_b[9*c +: 9]};
                end
                S_ARG: begin
                    best_s <= nb_s;
                    best_i <= nb_i;
                    ak     <= ak + 4'd1;
                    if (ak == ARG_LAST) begin
                        digit <= nb_i;
                        score <= nb_s;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_l5_fc_argmax.sv
// Bench for l5_fc_argmax: four instances with different ROM contents and
// read latencies, driven one at a time by a directed sequence.
module tb_l5_fc_argmax;

    function automatic logic [5759:0] gen_wg();
        logic [5759:0] v;
        int w;
        v = '0;
        for (int i = 0; i < 64; i++)
            for (int c = 0; c < 10; c++) begin
                w = ((i*7 + c*13 + i*c) % 31) - 15;
                v[90*i + 9*c +: 9] = 9'(w);
            end
        return v;
    endfunction

    function automatic logic [5759:0] gen_w1();
        logic [5759:0] v;
        v = '0;
        v[90*32 + 9*6 +: 9] = 9'd100;
        return v;
    endfunction

    function automatic logic [5759:0] gen_wall(input int val);
        logic [5759:0] v;
        v = '0;
        for (int i = 0; i < 640; i++) v[9*i +: 9] = 9'(val);
        return v;
    endfunction

    function automatic logic [89:0] gen_ba();
        logic [89:0] v;
        int t [10];
        t = '{-5, 3, 7, 7, -1, 0, 2, 1, -9, 4};
        v = '0;
        for (int c = 0; c < 10; c++) v[9*c +: 9] = 9'(t[c]);
        return v;
    endfunction

    function automatic logic [89:0] gen_ball(input int val);
        logic [89:0] v;
        v = '0;
        for (int c = 0; c < 10; c++) v[9*c +: 9] = 9'(val);
        return v;
    endfunction

    localparam logic [5759:0] W_G   = gen_wg();
    localparam logic [5759:0] W_1   = gen_w1();
    localparam logic [5759:0] W_M1  = gen_wall(-1);
    localparam logic [89:0]   B_A   = gen_ba();
    localparam logic [89:0]   B_0   = '0;
    localparam logic [89:0]   B_M1  = gen_ball(-1);

    // clock and reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic              strt_v  [4];
    logic              tx_v    [4];
    logic [15:0][17:0] din_v   [4];
    logic [3:0]        digit_v [4];
    logic [35:0]       score_v [4];
    logic              vld_v   [4];
    logic              busy_v  [4];

    int n_vec = 0;
    int n_err = 0;
    logic [39:0] exp_q [$];

    logic [17:0] frm_z [64];
    logic [17:0] frm_a [64];
    logic [17:0] frm_b [64];
    logic [17:0] frm_s [64];
    logic [17:0] frm_1 [64];

    l5_fc_argmax #(.RD_LAT(1), .WGT(W_G), .BIAS(B_A)) u0 (
        .clk(clk), .rst_n(rst_n), .strt(strt_v[0]), .tx_done(tx_v[0]), .din(din_v[0]),
        .digit(digit_v[0]), .score(score_v[0]), .vld(vld_v[0]), .busy(busy_v[0]));
    l5_fc_argmax #(.RD_LAT(1), .WGT(W_1), .BIAS(B_0)) u1 (
        .clk(clk), .rst_n(rst_n), .strt(strt_v[1]), .tx_done(tx_v[1]), .din(din_v[1]),
        .digit(digit_v[1]), .score(score_v[1]), .vld(vld_v[1]), .busy(busy_v[1]));
    l5_fc_argmax #(.RD_LAT(1), .WGT(W_M1), .BIAS(B_M1)) u2 (
        .clk(clk), .rst_n(rst_n), .strt(strt_v[2]), .tx_done(tx_v[2]), .din(din_v[2]),
        .digit(digit_v[2]), .score(score_v[2]), .vld(vld_v[2]), .busy(busy_v[2]));
    l5_fc_argmax #(.RD_LAT(2), .WGT(W_G), .BIAS(B_A)) u3 (
        .clk(clk), .rst_n(rst_n), .strt(strt_v[3]), .tx_done(tx_v[3]), .din(din_v[3]),
        .digit(digit_v[3]), .score(score_v[3]), .vld(vld_v[3]), .busy(busy_v[3]));

    // reference model: full dot products, then strict-greater argmax
    function automatic logic [39:0] model(input logic [17:0] d [64],
                                          input logic [5759:0] wv,
                                          input logic [89:0] bv);
        int s, bs, bi;
        bs = 0;
        bi = 0;
        for (int c = 0; c < 10; c++) begin
            s = int'($signed(bv[9*c +: 9]));
            for (int i = 0; i < 64; i++)
                s += int'($signed(d[i])) * int'($signed(wv[90*i + 9*c +: 9]));
            if (c == 0 || s > bs) begin
                bs = s;
                bi = c;
            end
        end
        return {4'(bi), 36'(bs)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one frame on instance d. The call cycle is t0 (strt high).
    // abort_k: pulse tx_done in cycle t0+abort_k. rst_k: pulse rst_n in t0+rst_k.
    task automatic run_frame(input int d, input int rdlat, input logic [17:0] data [64],
                             input int abort_k, input int rst_k);
        int k_hit;
        int bad;
        logic [39:0] e;
        k_hit = 0;
        bad   = 0;
        strt_v[d] = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (abort_k != 0 && k == abort_k + 1) begin
                tx_v[d] = 1'b0;
                check("abort_busy", 64'(busy_v[d]), 64'd0);
                check("abort_vld", 64'(vld_v[d]), 64'd0);
                return;
            end
            if (abort_k != 0 && k == abort_k) tx_v[d] = 1'b1;
            if (rst_k != 0 && k == rst_k) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_busy", 64'(busy_v[d]), 64'd0);
                check("rst_vld", 64'(vld_v[d]), 64'd0);
                check("rst_digit", 64'(digit_v[d]), 64'd0);
                check("rst_score", 64'(score_v[d]), 64'd0);
                @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end
            din_v[d] = '0;
            if (k >= rdlat && k <= rdlat + 3)
                for (int n = 0; n < 16; n++) din_v[d][n] = data[16*(k-rdlat) + n];
            if (vld_v[d]) begin
                k_hit = k;
                break;
            end
            if (!busy_v[d]) bad++;
        end
        check("vld_latency", 64'(k_hit), 64'(rdlat + 80));
        check("busy_in_frame", 64'(bad), 64'd0);
        check("busy_at_vld", 64'(busy_v[d]), 64'd0);
        check("sb_depth", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("digit", 64'(digit_v[d]), 64'(e[39:36]));
            check("score", 64'(score_v[d]), 64'(e[35:0]));
        end
    endtask

    // tx_done for one cycle; with keep_strt the following cycle is a new t0
    task automatic clear(input int d, input logic keep_strt);
        strt_v[d] = keep_strt;
        tx_v[d]   = 1'b1;
        @(posedge clk);
        #1;
        tx_v[d] = 1'b0;
        check("clr_vld", 64'(vld_v[d]), 64'd0);
        check("clr_busy", 64'(busy_v[d]), 64'd0);
        check("clr_digit", 64'(digit_v[d]), 64'd0);
        check("clr_score", 64'(score_v[d]), 64'd0);
    endtask

    initial begin
        logic [39:0] e3;
        rst_n = 1'b0;
        for (int d = 0; d < 4; d++) begin
            strt_v[d] = 1'b0;
            tx_v[d]   = 1'b0;
            din_v[d]  = '0;
        end
        for (int i = 0; i < 64; i++) begin
            frm_z[i] = '0;
            frm_a[i] = 18'(int'($urandom_range(0, 4000)) - 2000);
            frm_b[i] = 18'(int'($urandom_range(0, 4000)) - 2000);
            frm_s[i] = (i == 32) ? 18'd1000 : 18'd0;
            frm_1[i] = 18'd1;
        end

        // reset values
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            check("reset_digit", 64'(digit_v[d]), 64'd0);
            check("reset_score", 64'(score_v[d]), 64'd0);
            check("reset_vld", 64'(vld_v[d]), 64'd0);
            check("reset_busy", 64'(busy_v[d]), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // zero inputs: bias alone decides, tie 2/3 goes to 2
        exp_q.push_back({4'd2, 36'd7});
        run_frame(0, 1, frm_z, 0, 0);
        // tx_done with strt high: no frame that cycle, next one starts after
        clear(0, 1'b1);
        exp_q.push_back(model(frm_a, W_G, B_A));
        run_frame(0, 1, frm_a, 0, 0);
        clear(0, 1'b0);
        exp_q.push_back(model(frm_b, W_G, B_A));
        run_frame(0, 1, frm_b, 0, 0);
        clear(0, 1'b0);

        // tx_done in MAC cycle 30, strt kept high: restart from the next cycle
        run_frame(0, 1, frm_a, 35, 0);
        exp_q.push_back(model(frm_b, W_G, B_A));
        run_frame(0, 1, frm_b, 0, 0);
        clear(0, 1'b0);

        // reset pulse during ARG, strt kept high
        run_frame(0, 1, frm_b, 0, 75);
        exp_q.push_back(model(frm_a, W_G, B_A));
        run_frame(0, 1, frm_a, 0, 0);
        clear(0, 1'b0);

        // single contributing input/weight
        exp_q.push_back({4'd6, 36'd100000});
        run_frame(1, 1, frm_s, 0, 0);
        clear(1, 1'b0);

        // all-negative scores, full tie
        exp_q.push_back({4'd0, -36'sd65});
        run_frame(2, 1, frm_1, 0, 0);
        clear(2, 1'b0);

        // longer read latency, then strt held in DONE
        e3 = model(frm_a, W_G, B_A);
        exp_q.push_back(e3);
        run_frame(3, 2, frm_a, 0, 0);
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            check("hold_vld", 64'(vld_v[3]), 64'd1);
            check("hold_busy", 64'(busy_v[3]), 64'd0);
            check("hold_digit", 64'(digit_v[3]), 64'(e3[39:36]));
            check("hold_score", 64'(score_v[3]), 64'(e3[35:0]));
        end
        clear(3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
